uart_debug_unit: RTL and testbench

UART_DEBUG_UNIT -- requirements
Module: uart_debug_unit

---
 rtl/debug_pkg.sv | 23 ++
 rtl/uart_debug_if.sv | 29 ++
 rtl/word_assembler.sv | 52 +++++
 rtl/uart_debug_unit.sv | 177 +++++++++++++++++
 tb/tb_uart_debug_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/debug_pkg.sv
// Shared command/ack byte codes and FSM state encoding for the UART debug unit.
package debug_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadCnt,
    StLoadByte,
    StWrite,
    StSend
  } state_e;

  localparam logic [7:0] CmdLoad = 8'h4C;
  localparam logic [7:0] CmdRun  = 8'h52;
  localparam logic [7:0] CmdStep = 8'h53;
  localparam logic [7:0] CmdHalt = 8'h48;

  localparam logic [7:0] AckOk      = 8'h4B;
  localparam logic [7:0] AckErr     = 8'h45;
  localparam logic [7:0] AckTimeout = 8'h54;

  localparam logic [1:0] WsizeWord = 2'b10;

endpackage

// File: rtl/uart_debug_if.sv
// UART FIFO and instruction-memory write bundle; master is the debug unit side.
interface uart_debug_if #(
  parameter int unsigned NB_UART_DATA    = 8,
  parameter int unsigned NB_INSTRUCTION  = 32,
  parameter int unsigned IMEM_ADDR_WIDTH = 8
) ();

  logic [NB_UART_DATA-1:0]    i_rdata;
  logic                       i_rx_empty;
  logic                       o_ren;
  logic [NB_UART_DATA-1:0]    o_wdata;
  logic                       o_wen;
  logic                       i_tx_full;
  logic [NB_INSTRUCTION-1:0]  o_imem_data;
  logic [IMEM_ADDR_WIDTH-1:0] o_imem_waddr;
  logic                       o_imem_wen;
  logic [1:0]                 o_imem_wsize;

  modport master (
    input  i_rdata, i_rx_empty, i_tx_full,
    output o_ren, o_wdata, o_wen, o_imem_data, o_imem_waddr, o_imem_wen, o_imem_wsize
  );

  modport slave (
    output i_rdata, i_rx_empty, i_tx_full,
    input  o_ren, o_wdata, o_wen, o_imem_data, o_imem_waddr, o_imem_wen, o_imem_wsize
  );

endinterface

// File: rtl/word_assembler.sv
// Little-endian byte-to-word shift register with byte index and remaining-word counter.
module word_assembler import debug_pkg::*; #(
  parameter int unsigned NB_UART_DATA   = 8,
  parameter int unsigned NB_INSTRUCTION = 32,
  parameter int unsigned NB_COUNT       = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      cnt_load_i,
  input  logic [NB_COUNT-1:0]       cnt_val_i,
  input  logic                      byte_en_i,
  input  logic [NB_UART_DATA-1:0]   byte_data_i,
  input  logic                      word_taken_i,
  output logic [NB_INSTRUCTION-1:0] word_o,
  output logic                      byte_done_o,
  output logic                      last_word_o
);

  localparam int unsigned NBytes = NB_INSTRUCTION / NB_UART_DATA;
  localparam int unsigned IdxW   = (NBytes > 1) ? $clog2(NBytes) : 1;

  logic [NB_INSTRUCTION-1:0] word_q;
  logic [IdxW-1:0]           idx_q;
  logic [NB_COUNT-1:0]       cnt_q;

  assign byte_done_o = byte_en_i && (idx_q == IdxW'(NBytes - 1));
  assign last_word_o = (cnt_q == NB_COUNT'(1));
  assign word_o      = word_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (flush_i) begin
        idx_q <= '0;
      end else if (byte_en_i) begin
        // New bytes enter at the top so the first byte ends up in the low lane.
        word_q <= {byte_data_i, word_q[NB_INSTRUCTION-1:NB_UART_DATA]};
        idx_q  <= byte_done_o ? '0 : idx_q + 1'b1;
      end
      if (cnt_load_i) begin
        cnt_q <= cnt_val_i;
      end else if (word_taken_i) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_debug_unit.sv
// UART-driven debug controller: loads instruction memory and runs/steps/halts the CPU.
module uart_debug_unit import debug_pkg::*; #(
  parameter int unsigned NB_UART_DATA    = 8,
  parameter int unsigned NB_INSTRUCTION  = 32,
  parameter int unsigned IMEM_ADDR_WIDTH = 8,
  parameter int unsigned NB_TIMEOUT      = 20,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic       clk,
  input  logic       i_rst,
  uart_debug_if.master bus,
  output logic       o_cpu_en,
  output logic       o_running
);

  state_e                     state_q;
  logic [NB_UART_DATA-1:0]    wdata_q;
  logic                       wen_q;
  logic [NB_INSTRUCTION-1:0]  imem_data_q;
  logic [IMEM_ADDR_WIDTH-1:0] imem_waddr_q;
  logic [IMEM_ADDR_WIDTH-1:0] addr_q;
  logic                       imem_wen_q;
  logic                       running_q;
  logic                       cpu_en_q;
  logic [NB_TIMEOUT-1:0]      to_q;

  logic                       rx_state;
  logic                       load_state;
  logic                       pop;
  logic                       timeout;
  logic                       cnt_load;
  logic                       byte_en;
  logic                       flush;
  logic [NB_INSTRUCTION-1:0]  word;
  logic                       byte_done;
  logic                       last_word;

  assign rx_state   = (state_q == StIdle) || (state_q == StLoadCnt) || (state_q == StLoadByte);
  assign load_state = (state_q == StLoadCnt) || (state_q == StLoadByte);
  // The RX FIFO is first-word-fall-through: data is consumed on the popping edge.
  assign pop        = rx_state && !bus.i_rx_empty;
  assign timeout    = load_state && !pop && (to_q == NB_TIMEOUT'(TIMEOUT_CYCLES - 1));
  assign cnt_load   = (state_q == StLoadCnt) && pop && (bus.i_rdata != '0);
  assign byte_en    = (state_q == StLoadByte) && pop;
  assign flush      = timeout || (state_q == StIdle);

  word_assembler #(
    .NB_UART_DATA  (NB_UART_DATA),
    .NB_INSTRUCTION(NB_INSTRUCTION),
    .NB_COUNT      (NB_UART_DATA)
  ) u_word_assembler (
    .clk_i       (clk),
    .rst_ni      (i_rst),
    .flush_i     (flush),
    .cnt_load_i  (cnt_load),
    .cnt_val_i   (bus.i_rdata),
    .byte_en_i   (byte_en),
    .byte_data_i (bus.i_rdata),
    .word_taken_i(state_q == StWrite),
    .word_o      (word),
    .byte_done_o (byte_done),
    .last_word_o (last_word)
  );

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= StIdle;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      imem_data_q  <= '0;
      imem_waddr_q <= '0;
      addr_q       <= '0;
      imem_wen_q   <= 1'b0;
      running_q    <= 1'b0;
      cpu_en_q     <= 1'b0;
      to_q         <= '0;
    end else begin
      wen_q      <= 1'b0;
      imem_wen_q <= 1'b0;
      cpu_en_q   <= running_q;
      case (state_q)
        StIdle: begin
          to_q <= '0;
          if (pop) begin
            state_q <= StSend;
            case (bus.i_rdata)
              CmdLoad: begin
                if (running_q) wdata_q <= AckErr;
                else           state_q <= StLoadCnt;
              end
              CmdRun: begin
                running_q <= 1'b1;
                cpu_en_q  <= 1'b1;
                wdata_q   <= AckOk;
              end
              CmdStep: begin
                if (running_q) begin
                  wdata_q <= AckErr;
                end else begin
                  cpu_en_q <= 1'b1;
                  wdata_q  <= AckOk;
                end
              end
              CmdHalt: begin
                running_q <= 1'b0;
                cpu_en_q  <= 1'b0;
                wdata_q   <= AckOk;
              end
              default: wdata_q <= AckErr;
            endcase
          end
        end
        StLoadCnt: begin
          if (pop) begin
            to_q <= '0;
            if (bus.i_rdata == '0) begin
              wdata_q <= AckOk;
              state_q <= StSend;
            end else begin
              addr_q  <= '0;
              state_q <= StLoadByte;
            end
          end else if (timeout) begin
            to_q    <= '0;
            wdata_q <= AckTimeout;
            state_q <= StSend;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        StLoadByte: begin
          if (pop) begin
            to_q <= '0;
            if (byte_done) state_q <= StWrite;
          end else if (timeout) begin
            to_q    <= '0;
            wdata_q <= AckTimeout;
            state_q <= StSend;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        StWrite: begin
          to_q         <= '0;
          imem_wen_q   <= 1'b1;
          imem_data_q  <= word;
          imem_waddr_q <= addr_q;
          addr_q       <= addr_q + IMEM_ADDR_WIDTH'(4);
          if (last_word) begin
            wdata_q <= AckOk;
            state_q <= StSend;
          end else begin
            state_q <= StLoadByte;
          end
        end
        StSend: begin
          if (!bus.i_tx_full) begin
            wen_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_ren        = pop;
  assign bus.o_wdata      = wdata_q;
  assign bus.o_wen        = wen_q;
  assign bus.o_imem_data  = imem_data_q;
  assign bus.o_imem_waddr = imem_waddr_q;
  assign bus.o_imem_wen   = imem_wen_q;
  assign bus.o_imem_wsize = WsizeWord;
  assign o_cpu_en         = cpu_en_q;
  assign o_running        = running_q;

endmodule

// File: tb/tb_uart_debug_unit.sv
// Directed bench for uart_debug_unit: load, run/step/halt, timeout, wrap, backpressure, reset.
module tb_uart_debug_unit;

  logic clk = 1'b0;
  logic i_rst;
  logic cpu_en;
  logic running;

  always #5 clk = ~clk;

  uart_debug_if #(
    .NB_UART_DATA   (8),
    .NB_INSTRUCTION (32),
    .IMEM_ADDR_WIDTH(4)
  ) bus ();

  uart_debug_unit #(
    .NB_UART_DATA   (8),
    .NB_INSTRUCTION (32),
    .IMEM_ADDR_WIDTH(4),
    .NB_TIMEOUT     (20),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk      (clk),
    .i_rst    (i_rst),
    .bus      (bus),
    .o_cpu_en (cpu_en),
    .o_running(running)
  );

  // RX FIFO model (first-word-fall-through)
  logic [7:0] rx_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.i_rx_empty = (rd_ptr == wr_ptr);
  assign bus.i_rdata    = rx_mem[rd_ptr[5:0]];
  always @(posedge clk) if (bus.o_ren) rd_ptr <= rd_ptr + 1;

  // Output monitors
  logic [7:0]  tx_log   [0:31];
  logic [3:0]  wr_addr  [0:31];
  logic [31:0] wr_data  [0:31];
  int tx_n   = 0;
  int imem_n = 0;
  int cpu_hi = 0;
  always @(negedge clk) begin
    if (bus.o_wen) begin
      tx_log[tx_n] = bus.o_wdata;
      tx_n++;
    end
    if (bus.o_imem_wen) begin
      wr_addr[imem_n] = bus.o_imem_waddr;
      wr_data[imem_n] = bus.o_imem_data;
      imem_n++;
    end
    if (cpu_en) cpu_hi++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_mem[wr_ptr[5:0]] = b;
    wr_ptr++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int c = 0;
    while (tx_n < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    idle(1);
    check("tx_count", tx_n, n);
  endtask

  int n0, hi0, c;
  logic [31:0] w;

  initial begin
    for (int i = 0; i < 64; i++) rx_mem[i] = 8'h00;
    i_rst = 1'b0;
    bus.i_tx_full = 1'b0;
    idle(3);

    // Reset values
    check("rst_ren", bus.o_ren, 0);
    check("rst_wen", bus.o_wen, 0);
    check("rst_wdata", bus.o_wdata, 0);
    check("rst_imem_wen", bus.o_imem_wen, 0);
    check("rst_imem_data", bus.o_imem_data, 0);
    check("rst_imem_waddr", bus.o_imem_waddr, 0);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_running", running, 0);
    check("wsize", bus.o_imem_wsize, 2);
    i_rst = 1'b1;
    idle(2);

    // Two-word load
    push(8'h4C); push(8'h02);
    push(8'h13); push(8'h00); push(8'h00); push(8'h00);
    push(8'h93); push(8'h00); push(8'h10); push(8'h00);
    wait_tx(1, 300);
    check("load_ack", tx_log[0], 8'h4B);
    check("load_wr_count", imem_n, 2);
    check("load_addr0", wr_addr[0], 4'h0);
    check("load_data0", wr_data[0], 32'h0000_0013);
    check("load_addr1", wr_addr[1], 4'h4);
    check("load_data1", wr_data[1], 32'h0010_0093);
    idle(3);
    check("hold_data", bus.o_imem_data, 32'h0010_0093);
    check("hold_addr", bus.o_imem_waddr, 4'h4);
    check("load_single_ack", tx_n, 1);

    // Run / step / halt
    push(8'h52);
    wait_tx(2, 50);
    check("run_ack", tx_log[1], 8'h4B);
    check("run_flag", running, 1);
    idle(5);
    check("run_cpu_en", cpu_en, 1);
    push(8'h53);
    wait_tx(3, 50);
    check("step_while_run_ack", tx_log[2], 8'h45);
    check("step_while_run_cpu_en", cpu_en, 1);
    push(8'h48);
    wait_tx(4, 50);
    check("halt_ack", tx_log[3], 8'h4B);
    idle(2);
    check("halt_cpu_en", cpu_en, 0);
    check("halt_running", running, 0);
    hi0 = cpu_hi;
    push(8'h53);
    wait_tx(5, 50);
    idle(5);
    check("step_ack", tx_log[4], 8'h4B);
    check("step_width", cpu_hi - hi0, 1);

    // Inter-byte timeout
    n0 = imem_n;
    push(8'h4C); push(8'h01); push(8'hAA);
    idle(30);
    check("timeout_not_early", tx_n, 5);
    wait_tx(6, 400);
    check("timeout_ack", tx_log[5], 8'h54);
    check("timeout_no_wen", imem_n, n0);
    push(8'h48);
    wait_tx(7, 50);
    check("after_timeout_ack", tx_log[6], 8'h4B);

    // Address wrap with TX backpressure on the final ack
    bus.i_tx_full = 1'b1;
    n0 = imem_n;
    push(8'h4C); push(8'h05);
    for (int k = 0; k < 5; k++) begin
      w = 32'hC0DE_0000 + k;
      for (int b = 0; b < 4; b++) push(w[b*8 +: 8]);
    end
    c = 0;
    while (imem_n < n0 + 5 && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("wrap_wr_count", imem_n, n0 + 5);
    for (int k = 0; k < 5; k++) begin
      check("wrap_addr", wr_addr[n0 + k], (k * 4) % 16);
      check("wrap_data", wr_data[n0 + k], 32'hC0DE_0000 + k);
    end
    idle(20);
    check("bp_held", tx_n, 7);
    bus.i_tx_full = 1'b0;
    idle(10);
    check("bp_released_once", tx_n, 8);
    check("bp_ack", tx_log[7], 8'h4B);

    // Unknown command
    push(8'h00);
    wait_tx(9, 50);
    check("unknown_ack", tx_log[8], 8'h45);

    // Reset in the middle of a word
    n0 = imem_n;
    push(8'h4C); push(8'h01); push(8'h11); push(8'h22);
    c = 0;
    while (rd_ptr != wr_ptr && c < 100) begin
      @(negedge clk);
      c++;
    end
    idle(2);
    i_rst = 1'b0;
    #1;
    check("mid_rst_wdata", bus.o_wdata, 0);
    check("mid_rst_imem_data", bus.o_imem_data, 0);
    check("mid_rst_imem_waddr", bus.o_imem_waddr, 0);
    check("mid_rst_imem_wen", bus.o_imem_wen, 0);
    check("mid_rst_wen", bus.o_wen, 0);
    check("mid_rst_cpu_en", cpu_en, 0);
    check("mid_rst_running", running, 0);
    idle(2);
    i_rst = 1'b1;
    idle(20);
    check("mid_rst_no_wen", imem_n, n0);
    push(8'h48);
    wait_tx(10, 50);
    check("post_rst_ack", tx_log[9], 8'h4B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
